fc_runner_vec: RTL and testbench

Parametrised successor to the scalar fully-connected runner: computes PAR_OUT output channels per pass over a buffered input vector, with per-lane requantisation and optional ReLU6. Sits after global pooling in the classifier head. It reads activations from the feature memory through a 1-cycle-latency port and streams int8 results to the output memory through a ready/enable write port. Fixed-function weight/quant parameter ROMs are addressed externally.

---
 rtl/fc_runner_vec.sv | 186 ++++++++++++++++++
 tb/tb_fc_runner_vec.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_runner_vec.sv
// fc_runner_vec: PAR_OUT-lane fully-connected runner over a buffered input vector with int8 requantisation.
// Optional FC_RUNNER_VEC_RELU6_EN adds the cfg_relu6_max port and a ReLU6 clamp after saturation.
module fc_runner_vec #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int MUL_W     = 16,
    parameter int BIAS_W    = 32,
    parameter int SHIFT_W   = 6,
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 16,
    parameter int MAX_IN_CH = 1024,
    parameter int PAR_OUT   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    input  logic [DIM_W-1:0]            cfg_in_c,
    input  logic [DIM_W-1:0]            cfg_out_c,
    input  logic [ADDR_W-1:0]           cfg_in_base,
    input  logic [ADDR_W-1:0]           cfg_out_base,
`ifdef FC_RUNNER_VEC_RELU6_EN
    input  logic signed [DATA_W-1:0]    cfg_relu6_max,
`endif
    output logic                        in_rd_en,
    output logic [ADDR_W-1:0]           in_rd_addr,
    input  logic signed [DATA_W-1:0]    in_rd_data,
    output logic                        out_wr_en,
    input  logic                        out_wr_ready,
    output logic [ADDR_W-1:0]           out_wr_addr,
    output logic [DATA_W-1:0]           out_wr_data,
    output logic [DIM_W-1:0]            wt_in_idx,
    output logic [DIM_W-1:0]            wt_grp,
    input  logic [PAR_OUT*DATA_W-1:0]   wt_data,
    input  logic [PAR_OUT*MUL_W-1:0]    q_mul,
    input  logic [PAR_OUT*BIAS_W-1:0]   q_bias,
    input  logic [PAR_OUT*SHIFT_W-1:0]  q_shift
);
    localparam int AW    = MAX_IN_CH > 1 ? $clog2(MAX_IN_CH) : 1;
    localparam int LW    = PAR_OUT > 1 ? $clog2(PAR_OUT) : 1;
    localparam int SUM_W = (ACC_W > BIAS_W ? ACC_W : BIAS_W) + 1;
    localparam int P_W   = SUM_W + MUL_W + 1;
    localparam logic signed [P_W-1:0] QMAX = P_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [P_W-1:0] QMIN = -QMAX - 1;

    typedef enum logic [2:0] {IDLE, LOAD, ACCUM, QUANT, WRITE, NEXT, DONE} state_t;
    state_t state, state_nx;

    logic [DIM_W-1:0] k, g, in_c, out_c, gbase, rem, n_g;
    logic [LW-1:0] lane;
    logic [ADDR_W-1:0] in_base, out_base;
    logic signed [DATA_W-1:0] mem [MAX_IN_CH];
    logic signed [DATA_W-1:0] mem_rd;
    logic signed [ACC_W-1:0] acc [PAR_OUT];
    logic signed [DATA_W-1:0] res [PAR_OUT];
    logic signed [DATA_W-1:0] w [PAR_OUT];
    logic signed [2*DATA_W-1:0] prod [PAR_OUT];
    logic signed [SUM_W-1:0] sum [PAR_OUT];
    logic signed [P_W-1:0] prd [PAR_OUT];
    logic signed [P_W-1:0] rnd [PAR_OUT];
    logic signed [P_W-1:0] shd [PAR_OUT];
    logic signed [DATA_W-1:0] sat [PAR_OUT];
    logic signed [DATA_W-1:0] qv [PAR_OUT];
    logic [SHIFT_W-1:0] sh [PAR_OUT];
    logic last_grp, wr_fire;
`ifdef FC_RUNNER_VEC_RELU6_EN
    logic signed [DATA_W-1:0] relu_max;
`endif

    assign gbase    = DIM_W'(g * PAR_OUT);
    assign rem      = out_c - gbase;
    assign n_g      = rem < DIM_W'(PAR_OUT) ? rem : DIM_W'(PAR_OUT);
    assign last_grp = rem <= DIM_W'(PAR_OUT);
    assign wr_fire  = out_wr_en && out_wr_ready;
    assign mem_rd   = mem[AW'(k)];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (cfg_in_c == '0 || cfg_out_c == '0) ? DONE : LOAD;
            LOAD:    if (k == in_c) state_nx = ACCUM;
            ACCUM:   if (k == in_c - 1'b1) state_nx = QUANT;
            QUANT:   state_nx = WRITE;
            WRITE:   if (wr_fire && lane == LW'(n_g - 1'b1)) state_nx = NEXT;
            NEXT:    state_nx = last_grp ? DONE : ACCUM;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_comb begin
        busy        = state != IDLE;
        done        = state == DONE;
        in_rd_en    = state == LOAD && k != in_c;
        in_rd_addr  = in_rd_en ? in_base + ADDR_W'(k) : '0;
        out_wr_en   = state == WRITE;
        out_wr_addr = out_wr_en ? out_base + ADDR_W'(gbase) + ADDR_W'(lane) : '0;
        out_wr_data = out_wr_en ? res[lane] : '0;
        wt_in_idx   = k;
        wt_grp      = g;
    end

    // Requantise: round-half-up arithmetic shift, saturate to DATA_W, then the optional ReLU6 clamp.
    always_comb begin
        for (int l = 0; l < PAR_OUT; l++) begin
            w[l]    = $signed(wt_data[l*DATA_W +: DATA_W]);
            prod[l] = mem_rd * w[l];
            sh[l]   = q_shift[l*SHIFT_W +: SHIFT_W];
            sum[l]  = SUM_W'(acc[l]) + SUM_W'($signed(q_bias[l*BIAS_W +: BIAS_W]));
            prd[l]  = P_W'(sum[l]) * P_W'($signed(q_mul[l*MUL_W +: MUL_W]));
            rnd[l]  = sh[l] == '0 ? '0 : P_W'(1) << (sh[l] - 1'b1);
            shd[l]  = (prd[l] + rnd[l]) >>> sh[l];
            sat[l]  = shd[l] > QMAX ? DATA_W'(QMAX) : shd[l] < QMIN ? DATA_W'(QMIN) : DATA_W'(shd[l]);
`ifdef FC_RUNNER_VEC_RELU6_EN
            qv[l]   = sat[l] < 0 ? '0 : sat[l] > relu_max ? relu_max : sat[l];
`else
            qv[l]   = sat[l];
`endif
        end
    end

    // Read data returns one cycle after its strobe, so slot k-1 is captured while k is issued.
    always_ff @(posedge clk) begin
        if (state == LOAD && k != '0) mem[AW'(k - 1'b1)] <= in_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            g        <= '0;
            lane     <= '0;
            in_c     <= '0;
            out_c    <= '0;
            in_base  <= '0;
            out_base <= '0;
`ifdef FC_RUNNER_VEC_RELU6_EN
            relu_max <= '0;
`endif
            for (int l = 0; l < PAR_OUT; l++) begin
                acc[l] <= '0;
                res[l] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    in_c     <= cfg_in_c > DIM_W'(MAX_IN_CH) ? DIM_W'(MAX_IN_CH) : cfg_in_c;
                    out_c    <= cfg_out_c;
                    in_base  <= cfg_in_base;
                    out_base <= cfg_out_base;
`ifdef FC_RUNNER_VEC_RELU6_EN
                    relu_max <= cfg_relu6_max;
`endif
                    k        <= '0;
                    g        <= '0;
                end
                LOAD: begin
                    k <= k == in_c ? '0 : k + 1'b1;
                    if (k == in_c) for (int l = 0; l < PAR_OUT; l++) acc[l] <= '0;
                end
                ACCUM: begin
                    k <= k == in_c - 1'b1 ? '0 : k + 1'b1;
                    for (int l = 0; l < PAR_OUT; l++) acc[l] <= acc[l] + ACC_W'(prod[l]);
                end
                QUANT: begin
                    lane <= '0;
                    for (int l = 0; l < PAR_OUT; l++) res[l] <= qv[l];
                end
                WRITE: if (wr_fire) lane <= lane + 1'b1;
                NEXT: begin
                    g <= g + 1'b1;
                    k <= '0;
                    for (int l = 0; l < PAR_OUT; l++) acc[l] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_runner_vec.sv
// tb_fc_runner_vec: randomised and directed runs of fc_runner_vec scored against a plain-arithmetic model.
module tb_fc_runner_vec;
    localparam int P = 4, MAXC = 16, NO = 16, NI = 32;

    typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;

    logic clk = 0, rst = 1, start = 0, abort = 0, out_wr_ready = 1;
    logic busy, done, in_rd_en, out_wr_en;
    logic [15:0] cfg_in_c = 0, cfg_out_c = 0;
    logic [31:0] cfg_in_base = 0, cfg_out_base = 0;
`ifdef FC_RUNNER_VEC_RELU6_EN
    logic signed [7:0] cfg_relu6_max = 6;
`endif
    logic [31:0] in_rd_addr, out_wr_addr;
    logic signed [7:0] in_rd_data = 0;
    logic [7:0] out_wr_data;
    logic [15:0] wt_in_idx, wt_grp;
    logic [P*8-1:0] wt_data;
    logic [P*16-1:0] q_mul;
    logic [P*32-1:0] q_bias;
    logic [P*6-1:0] q_shift;

    logic signed [7:0] fmem [256];
    logic signed [7:0] wtab [NO][NI];
    logic signed [15:0] qm [NO];
    int qb [NO];
    logic [5:0] qs [NO];

    wr_t exp_q [$];
    int n_chk = 0, n_fail = 0, cyc = 0;
    int rd_cnt = 0, fires = 0, plan_skip = 0, stall_left = 0, exp_lo = 0, exp_hi = 0;
    logic [31:0] rd_base = 0;
    bit done_seen = 0, expect_done = 0, empty_run = 0;

    fc_runner_vec #(.MAX_IN_CH(MAXC), .PAR_OUT(P)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .cfg_in_c(cfg_in_c), .cfg_out_c(cfg_out_c), .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
`ifdef FC_RUNNER_VEC_RELU6_EN
        .cfg_relu6_max(cfg_relu6_max),
`endif
        .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .out_wr_en(out_wr_en), .out_wr_ready(out_wr_ready), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
        .wt_in_idx(wt_in_idx), .wt_grp(wt_grp), .wt_data(wt_data),
        .q_mul(q_mul), .q_bias(q_bias), .q_shift(q_shift)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (in_rd_en) in_rd_data <= fmem[in_rd_addr[7:0]];

    always_comb begin
        wt_data = '0;
        q_mul   = '0;
        q_bias  = '0;
        q_shift = '0;
        for (int l = 0; l < P; l++) if (int'(wt_grp) * P + l < NO) begin
            if (int'(wt_in_idx) < NI) wt_data[l*8 +: 8] = wtab[int'(wt_grp) * P + l][int'(wt_in_idx)];
            q_mul[l*16 +: 16]  = qm[int'(wt_grp) * P + l];
            q_bias[l*32 +: 32] = qb[int'(wt_grp) * P + l];
            q_shift[l*6 +: 6]  = qs[int'(wt_grp) * P + l];
        end
    end

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Output channel o over ic buffered inputs, straight from the arithmetic definition.
    function automatic logic [7:0] ref_out(input int o, input int ic, input logic [31:0] ib);
        longint acc = 0, p, r;
        for (int k = 0; k < ic; k++) acc += fmem[8'(ib + 32'(k))] * wtab[o][k];
        acc = longint'(int'(acc));
        p = (acc + longint'(qb[o])) * longint'(qm[o]);
        r = p;
        if (qs[o] != 0) r = r + (longint'(1) << (qs[o] - 1));
        r = r >>> qs[o];
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`ifdef FC_RUNNER_VEC_RELU6_EN
        if (r < 0) r = 0;
        if (r > longint'(cfg_relu6_max)) r = longint'(cfg_relu6_max);
`endif
        return r[7:0];
    endfunction

    // Monitor: drives write backpressure and scores every read, write and done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            out_wr_ready = !(out_wr_en && fires >= plan_skip && stall_left > 0);
            if (!out_wr_ready) stall_left--;
            if (in_rd_en) begin
                chk("rd_addr", in_rd_addr, rd_base + 32'(rd_cnt));
                rd_cnt++;
            end
            if (out_wr_en) begin
                if (exp_q.size() == 0) chk("unexpected_write", out_wr_en, 0);
                else begin
                    chk("wr_addr", out_wr_addr, exp_q[0].a);
                    chk("wr_data", out_wr_data, exp_q[0].d);
                    if (out_wr_ready) void'(exp_q.pop_front());
                end
                if (out_wr_ready) fires++;
            end
            if (done) begin
                done_seen = 1;
                if (!expect_done) chk("unexpected_done", done, 0);
                else if (exp_lo == exp_hi) chk("done_cycle", cyc, exp_lo);
                else chk("done_cycle_range", (cyc >= exp_lo && cyc <= exp_hi) ? 1 : 0, 1);
            end
        end
    end

    // mode 0: normal, 1: abort mid-ACCUM, 2: start pulse while busy.
    task automatic run(input int ic, input int oc, input logic [31:0] ib, input logic [31:0] ob,
                       input int skip, input int stall, input int mode);
        int eic, tot, t;
        eic = ic > MAXC ? MAXC : ic;
        @(posedge clk); #1;
        cfg_in_c = 16'(ic); cfg_out_c = 16'(oc); cfg_in_base = ib; cfg_out_base = ob;
        rd_base = ib; rd_cnt = 0; fires = 0; plan_skip = skip; stall_left = stall; done_seen = 0;
        exp_q.delete();
        empty_run = (ic == 0 || oc == 0);
        if (empty_run) begin
            exp_lo = cyc + 1;
            exp_hi = cyc + 2;
        end else begin
            tot = 1 + eic + 1;
            for (int g = 0; g * P < oc; g++) tot += eic + 2 + ((oc - g * P) < P ? oc - g * P : P);
            exp_lo = cyc + tot + stall;
            exp_hi = exp_lo;
            if (mode != 1) for (int o = 0; o < oc; o++) exp_q.push_back('{ob + 32'(o), ref_out(o, eic, ib)});
        end
        expect_done = (mode != 1);
        start = 1;
        @(posedge clk); #1 start = 0;
        if (mode == 1) begin
            repeat (eic + 3) @(posedge clk);
            #1 abort = 1;
            @(posedge clk); #1 abort = 0;
            @(negedge clk);
            chk("abort_busy", busy, 0);
            repeat (40) @(negedge clk);
            chk("abort_no_done", done_seen, 0);
            chk("abort_no_write", fires, 0);
        end else begin
            if (mode == 2) begin
                repeat (3) @(posedge clk);
                #1 cfg_in_c = 0; cfg_out_c = 1; start = 1;
                @(posedge clk); #1 start = 0;
            end
            t = 0;
            while (!done_seen && t < 3000) begin
                @(negedge clk);
                t++;
            end
            chk("done_seen", done_seen, 1);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("writes_left", exp_q.size(), 0);
            chk("read_count", rd_cnt, empty_run ? 0 : eic);
            chk("write_count", fires, empty_run ? 0 : oc);
        end
    endtask

    task automatic fill_plain();
        for (int i = 0; i < 256; i++) fmem[i] = 0;
        for (int o = 0; o < NO; o++) begin
            for (int k = 0; k < NI; k++) wtab[o][k] = 1;
            qm[o] = 1; qb[o] = 0; qs[o] = 0;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) fmem[i] = 8'($urandom);
        for (int o = 0; o < NO; o++) begin
            for (int k = 0; k < NI; k++) wtab[o][k] = 8'($urandom);
            qm[o] = 16'($urandom_range(0, 3000));
            qb[o] = int'($urandom_range(0, 4000)) - 2000;
            qs[o] = 6'($urandom_range(0, 20));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_plain();
        start = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", in_rd_en, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_rd_addr", in_rd_addr, 0);
        chk("rst_wr_addr", out_wr_addr, 0);
        chk("rst_wr_data", out_wr_data, 0);
        chk("rst_wt_idx", wt_in_idx, 0);
        chk("rst_wt_grp", wt_grp, 0);
        @(posedge clk); #1 start = 0; rst = 0;

        for (int k = 0; k < 4; k++) fmem[16 + k] = 8'(k + 1);
        run(4, 3, 32'h10, 32'h100, 0, 0, 0);

        fill_plain();
        fmem[8'h40] = -3; fmem[8'h41] = 100;
        wtab[0][0] = 1; wtab[0][1] = 0;   qs[0] = 1;
        wtab[1][0] = 0; wtab[1][1] = 10;
        wtab[2][0] = 1; wtab[2][1] = 0;
        wtab[3][0] = 0; wtab[3][1] = -10;
        run(2, 4, 32'h40, 32'h200, 0, 0, 0);

        fill_plain();
        for (int k = 0; k < 4; k++) fmem[16 + k] = 8'(k + 1);
        run(4, 3, 32'h10, 32'h100, 1, 3, 0);

        fill_random();
        run(8, 5, 32'h20, 32'h300, 0, 0, 1);
        run(8, 5, 32'h20, 32'h300, 0, 0, 0);
        run(0, 3, 32'h20, 32'h300, 0, 0, 0);
        run(4, 0, 32'h20, 32'h300, 0, 0, 0);
        run(6, 6, 32'h30, 32'h400, 0, 0, 2);
        run(20, 4, 32'h50, 32'h500, 0, 1, 0);

        for (int i = 0; i < 8; i++) begin
            fill_random();
`ifdef FC_RUNNER_VEC_RELU6_EN
            cfg_relu6_max = 8'($urandom_range(0, 127));
`endif
            run(int'($urandom_range(1, MAXC + 2)), int'($urandom_range(1, NO)),
                32'($urandom_range(0, 200)), 32'($urandom_range(0, 4096)), 0, int'($urandom_range(0, 3)), 0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
